// File: rtl/adc_capture_pkg.sv
// Shared constants, FSM state type and code saturation
// helper for the ADC result capture path.
package adc_capture_pkg;

   localparam int ADC_BITS  = 12;
   localparam int HALF_BITS = 6;
   localparam int MID_CODE  = 2048;
   localparam int OFS_BITS  = ADC_BITS + 1;
   localparam int CORR_BITS = ADC_BITS + 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LSB,
      COMMIT
   } cap_state_t;

   // Clamp a signed correction result into the unsigned code range.
   function automatic logic [ADC_BITS-1:0] sat_code(
      input logic signed [CORR_BITS-1:0] v
   );
      if (v[CORR_BITS-1])
         return '0;
      else if (|v[CORR_BITS-2:ADC_BITS])
         return '1;
      else
         return v[ADC_BITS-1:0];
   endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Small synchronous result FIFO with occupancy counter.
// A push while full is accepted only when a pop frees a slot.
module adc_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr_q];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/adc_data_capture.sv
// Reassembles split ADC half-words, applies offset correction
// and queues corrected codes toward the digital back end.
module adc_data_capture
   import adc_capture_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [HALF_BITS-1:0]       data_i,
   input  logic                       clk_data_i,
   input  logic                       offset_cal_cycle_i,
   input  logic                       sample_i,
   input  logic                       cal_en_i,
   input  logic                       clear_i,
   input  logic                       res_ready_i,
   output logic                       res_valid_o,
   output logic [ADC_BITS-1:0]        res_data_o,
   output logic                       cal_valid_o,
   output logic signed [OFS_BITS-1:0] offset_o,
   output logic                       overflow_o,
   output logic                       frame_err_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   cap_state_t                 state_q, state_d;
   logic                       clk_data_q;
   logic [HALF_BITS-1:0]       msb_q;
   logic [ADC_BITS-1:0]        raw_q;
   logic                       is_cal_q;
   logic [TW-1:0]              timer_q;
   logic signed [OFS_BITS-1:0] offset_q;
   logic                       cal_valid_q;
   logic                       ovf_q;
   logic                       ferr_q;

   logic strobe;
   logic timeout;
   logic load_msb;
   logic load_raw;
   logic timer_clr;
   logic timer_inc;
   logic commit;
   logic ferr_set;
   logic ovf_set;
   logic push;
   logic pop;
   logic full;
   logic empty;

   logic signed [CORR_BITS-1:0] ofs_ext;
   logic signed [CORR_BITS-1:0] corr;
   logic [ADC_BITS-1:0]         corr_sat;

   assign strobe  = clk_data_i & ~clk_data_q;
   assign timeout = (timer_q == TW'(TIMEOUT_CYCLES));

   // Frame sequencing: MSB half, LSB half, then one commit cycle.
   always_comb begin
      state_d   = state_q;
      load_msb  = 1'b0;
      load_raw  = 1'b0;
      timer_clr = 1'b0;
      timer_inc = 1'b0;
      commit    = 1'b0;
      ferr_set  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (strobe) begin
               load_msb  = 1'b1;
               timer_clr = 1'b1;
               state_d   = WAIT_LSB;
            end
         end
         WAIT_LSB: begin
            if (strobe) begin
               load_raw = 1'b1;
               state_d  = COMMIT;
            end else if (sample_i || timeout) begin
               ferr_set = 1'b1;
               state_d  = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
            if (strobe) begin
               load_msb  = 1'b1;
               timer_clr = 1'b1;
               state_d   = WAIT_LSB;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ofs_ext  = cal_en_i ? {offset_q[OFS_BITS-1], offset_q} : '0;
   assign corr     = $signed({2'b00, raw_q}) - ofs_ext;
   assign corr_sat = sat_code(corr);

   assign push    = commit & ~is_cal_q;
   assign pop     = res_valid_o & res_ready_i;
   assign ovf_set = push & full & ~pop;

   // FSM state, strobe history, frame capture, timer and offset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         clk_data_q  <= 1'b0;
         msb_q       <= '0;
         raw_q       <= '0;
         is_cal_q    <= 1'b0;
         timer_q     <= '0;
         offset_q    <= '0;
         cal_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_data_q  <= clk_data_i;
         cal_valid_q <= commit & is_cal_q;
         if (load_msb)
            msb_q <= data_i;
         if (load_raw) begin
            raw_q    <= {msb_q, data_i};
            is_cal_q <= offset_cal_cycle_i;
         end
         if (timer_clr)
            timer_q <= '0;
         else if (timer_inc)
            timer_q <= timer_q + TW'(1);
         if (commit && is_cal_q)
            offset_q <= $signed({1'b0, raw_q})
                      - $signed(OFS_BITS'(MID_CODE));
      end
   end

   // Sticky error flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         if (clear_i) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
         end
         if (ovf_set)
            ovf_q <= 1'b1;
         if (ferr_set)
            ferr_q <= 1'b1;
      end
   end

   adc_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADC_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (corr_sat),
      .rd_data (res_data_o),
      .full    (full),
      .empty   (empty)
   );

   assign res_valid_o = ~empty;
   assign cal_valid_o = cal_valid_q;
   assign offset_o    = offset_q;
   assign overflow_o  = ovf_q;
   assign frame_err_o = ferr_q;

endmodule
